morph_close_ctrl: RTL

MORPH_CLOSE_CTRL -- requirements
Module: morph_close_ctrl

---
 rtl/morph_pkg.sv | 33 +++
 rtl/pix_pos_cnt.sv | 59 +++++
 rtl/morph_close_ctrl.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/morph_pkg.sv
// Shared definitions for the morphological closing controller: FSM encoding,
// counter widths and the frame-size derivations used by the top and its counters.
package morph_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD_D = 3'd1,
    ST_FL_D = 3'd2,
    ST_DR_D = 3'd3,
    ST_RD_E = 3'd4,
    ST_FL_E = 3'd5,
    ST_DR_E = 3'd6,
    ST_DONE = 3'd7
  } state_t;

  localparam int ADDR_W = 16;
  localparam int POS_W  = 11;
  // Engine input index covers N read pixels plus FILL pad pixels, so it needs one extra bit.
  localparam int IDX_W  = ADDR_W + 1;

  function automatic int fill_len(input int pic_width);
    return pic_width + 1;
  endfunction

  function automatic int pix_total(input int pic_width, input int pic_height);
    return pic_width * pic_height;
  endfunction

  function automatic logic is_erode(input state_t s);
    return (s == ST_RD_E) || (s == ST_FL_E) || (s == ST_DR_E);
  endfunction

endpackage

// File: rtl/pix_pos_cnt.sv
// Column/row/linear position tracker for the write side; flags pixels on the
// image border so the engine can treat edge outputs specially.
module pix_pos_cnt
  import morph_pkg::*;
#(
  parameter logic [10:0] PIC_WIDTH  = 11'd250,
  parameter logic [10:0] PIC_HEIGHT = 11'd250
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] addr,
  output logic              border
);

  localparam logic [POS_W-1:0] LAST_COL = PIC_WIDTH - 11'd1;
  localparam logic [POS_W-1:0] LAST_ROW = PIC_HEIGHT - 11'd1;

  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [POS_W-1:0]  col_q, col_d;
  logic [POS_W-1:0]  row_q, row_d;

  always_comb begin
    addr_d = addr_q;
    col_d  = col_q;
    row_d  = row_q;
    if (clr) begin
      addr_d = '0;
      col_d  = '0;
      row_d  = '0;
    end else if (inc) begin
      addr_d = addr_q + 16'd1;
      if (col_q == LAST_COL) begin
        col_d = '0;
        row_d = row_q + 11'd1;
      end else begin
        col_d = col_q + 11'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      col_q  <= '0;
      row_q  <= '0;
    end else begin
      addr_q <= addr_d;
      col_q  <= col_d;
      row_q  <= row_d;
    end
  end

  assign addr   = addr_q;
  assign border = (row_q == '0) || (row_q == LAST_ROW) ||
                  (col_q == '0) || (col_q == LAST_COL);

endmodule

// File: rtl/morph_close_ctrl.sv
// Sequencer for a morphological closing: a dilate pass over the source image into
// an intermediate buffer, then an erode pass from that buffer to the final output.
module morph_close_ctrl
  import morph_pkg::*;
#(
  parameter logic [10:0] PIC_WIDTH  = 11'd250,
  parameter logic [10:0] PIC_HEIGHT = 11'd250,
  parameter int          PIPE_LAT   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              pix_valid,
  output logic              busy,
  output logic              rd_req,
  output logic              rd_sel,
  output logic              op_sel,
  output logic              eng_valid,
  output logic              eng_pad,
  output logic              wr_en,
  output logic              wr_sel,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_border,
  output logic              frame_done
);

  localparam int FILL = fill_len(int'(PIC_WIDTH));
  localparam int N    = pix_total(int'(PIC_WIDTH), int'(PIC_HEIGHT));

  localparam logic [ADDR_W-1:0] LAST_PIX   = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] LAST_FILL  = ADDR_W'(FILL - 1);
  localparam logic [ADDR_W-1:0] LAST_DRAIN = ADDR_W'(PIPE_LAT - 1);
  localparam logic [IDX_W-1:0]  FIRST_OUT  = IDX_W'(FILL);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pix_cnt_q, pix_cnt_d;
  logic [ADDR_W-1:0] seq_cnt_q, seq_cnt_d;
  logic [IDX_W-1:0]  eng_idx_q, eng_idx_d;
  logic [PIPE_LAT-1:0] dly_q;

  logic pass_entry;
  logic erode;
  logic out_mark;
  logic pos_clr;
  logic pos_border;

  always_comb begin
    state_d    = state_q;
    pix_cnt_d  = pix_cnt_q;
    seq_cnt_d  = seq_cnt_q;
    eng_idx_d  = eng_idx_q;
    pass_entry = 1'b0;
    rd_req     = 1'b0;
    eng_valid  = 1'b0;
    eng_pad    = 1'b0;
    frame_done = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d    = ST_RD_D;
          pass_entry = 1'b1;
        end
      end
      ST_RD_D, ST_RD_E: begin
        rd_req    = 1'b1;
        eng_valid = pix_valid;
        if (pix_valid) begin
          if (pix_cnt_q == LAST_PIX) begin
            pix_cnt_d = '0;
            state_d   = (state_q == ST_RD_D) ? ST_FL_D : ST_FL_E;
          end else begin
            pix_cnt_d = pix_cnt_q + 16'd1;
          end
        end
      end
      ST_FL_D, ST_FL_E: begin
        // Pad pixels push the last image rows through the window engine.
        eng_valid = 1'b1;
        eng_pad   = 1'b1;
        if (seq_cnt_q == LAST_FILL) begin
          seq_cnt_d = '0;
          state_d   = (state_q == ST_FL_D) ? ST_DR_D : ST_DR_E;
        end else begin
          seq_cnt_d = seq_cnt_q + 16'd1;
        end
      end
      ST_DR_D, ST_DR_E: begin
        if (seq_cnt_q == LAST_DRAIN) begin
          seq_cnt_d = '0;
          if (state_q == ST_DR_D) begin
            state_d    = ST_RD_E;
            pass_entry = 1'b1;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          seq_cnt_d = seq_cnt_q + 16'd1;
        end
      end
      ST_DONE: begin
        frame_done = !abort;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (eng_valid) begin
      eng_idx_d = eng_idx_q + 17'd1;
    end
    if (pass_entry) begin
      eng_idx_d = '0;
    end

    if (abort) begin
      state_d    = ST_IDLE;
      pix_cnt_d  = '0;
      seq_cnt_d  = '0;
      eng_idx_d  = '0;
      pass_entry = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      pix_cnt_q <= '0;
      seq_cnt_q <= '0;
      eng_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      pix_cnt_q <= pix_cnt_d;
      seq_cnt_q <= seq_cnt_d;
      eng_idx_q <= eng_idx_d;
    end
  end

  // Only engine inputs past the first FILL carry a complete 3x3 window worth writing.
  assign out_mark = eng_valid && (eng_idx_q >= FIRST_OUT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dly_q[0] <= 1'b0;
    end else if (abort) begin
      dly_q[0] <= 1'b0;
    end else begin
      dly_q[0] <= out_mark;
    end
  end

  generate
    for (genvar gi = 1; gi < PIPE_LAT; gi++) begin : g_dly
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dly_q[gi] <= 1'b0;
        end else if (abort) begin
          dly_q[gi] <= 1'b0;
        end else begin
          dly_q[gi] <= dly_q[gi-1];
        end
      end
    end
  endgenerate

  assign pos_clr = abort || pass_entry;

  pix_pos_cnt #(
    .PIC_WIDTH (PIC_WIDTH),
    .PIC_HEIGHT(PIC_HEIGHT)
  ) u_wr_pos (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (pos_clr),
    .inc   (wr_en),
    .addr  (wr_addr),
    .border(pos_border)
  );

  assign erode     = is_erode(state_q);
  assign busy      = (state_q != ST_IDLE);
  assign rd_sel    = erode;
  assign op_sel    = erode;
  assign wr_sel    = erode;
  assign wr_en     = dly_q[PIPE_LAT-1];
  assign wr_border = wr_en && pos_border;

endmodule
